// File: rtl/encoder_4_to_2_serial.sv
// ----------------------------------------------------------------------------
// encoder_4_to_2_serial
//
// Serial priority encoder. Accepts an N-bit request vector through a
// valid/ready handshake, latches it, then streams out the binary index of
// every set bit, lowest index first, one index per accepted output beat.
// It is the sequential inverse of a 2-to-4 decoder: a one-hot or multi-hot
// vector goes in, a stream of binary select codes comes out.
//
// Parameters:
//   N          width of the request vector (power of two, >= 2)
//   W          width of the output index, $clog2(N); derived, not overridden
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   ena        module enable; low stalls both handshakes and holds state
//   in         request vector
//   in_valid   in holds a vector to be accepted
//   in_ready   a vector can be accepted this cycle
//   out        binary index of the lowest pending set bit
//   out_valid  out holds a valid index
//   out_ready  downstream consumes out this cycle
//   out_last   out is the final pending bit of the latched vector
//   busy       a latched vector still has pending bits (not gated by ena)
// ----------------------------------------------------------------------------
module encoder_4_to_2_serial #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  localparam logic       IDLE = 1'b0;
  localparam logic       BUSY = 1'b1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic         state;
  logic [N-1:0] pending;
  logic [N-1:0] pending_rest;  // pending with its lowest set bit cleared
  logic         single_bit;
  logic         in_fire;
  logic         out_fire;

  // Handshake outputs. rst is folded in so nothing can transfer while the
  // block is being reset, even before the reset edge takes effect.
  assign in_ready  = ena & (state == IDLE) & ~rst;
  assign out_valid = ena & (state == BUSY) & ~rst;
  assign busy      = (state == BUSY);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Clearing the lowest set bit: x & (x - 1). Because beats always leave in
  // ascending order, the bit being emitted is always the lowest one, so this
  // is exactly "clear the bit at index out".
  assign pending_rest = pending & (pending - ONE);
  assign single_bit   = (pending != '0) && (pending_rest == '0);
  assign out_last     = out_valid & single_bit;

  // Lowest-set-bit index; scanning from the top lets the lowest hit win.
  always_comb begin
    // NOTE: give every always_comb output a default before any condition,
    // otherwise paths that skip the assignment infer a latch.
    out = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) out = W'(i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else if (state == IDLE) begin
      // An all-zero vector is accepted and dropped: no beats to emit.
      if (in_fire && (in != '0)) begin
        pending <= in;
        state   <= BUSY;
      end
    end else begin
      if (out_fire) begin
        pending <= pending_rest;
        if (single_bit) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_encoder_4_to_2_serial.sv
// ----------------------------------------------------------------------------
// tb_encoder_4_to_2_serial
//
// Scoreboard bench. Every accepted vector is expanded by a reference model
// into its list of expected beats (index + last flag) and pushed onto a
// queue; a monitor running on the falling edge pops and compares whenever
// an output beat is consumed, and also checks the handshake/busy outputs
// against the model's view of whether a vector is in flight.
// ----------------------------------------------------------------------------
module tb_encoder_4_to_2_serial;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic [N-1:0] in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;

  encoder_4_to_2_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] idx;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every set bit becomes one beat, ascending; the highest
  // set bit carries the last flag.
  function automatic void push_vector(input logic [N-1:0] v);
    int hi = -1;
    for (int i = 0; i < N; i++) if (v[i]) hi = i;
    for (int i = 0; i < N; i++) begin
      if (v[i]) exp_q.push_back('{idx: W'(i), last: (i == hi)});
    end
  endfunction

  // Monitor / scoreboard. Values sampled here are the ones the next rising
  // edge will act on.
  always @(negedge clk) begin
    logic exp_busy, exp_ready, exp_valid;
    exp_busy  = (exp_q.size() != 0);
    exp_ready = ena && !rst && !exp_busy;
    exp_valid = ena && !rst && exp_busy;
    check("busy", busy, exp_busy);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check("out_index", out, exp_q[0].idx);
      check("out_last", out_last, exp_q[0].last);
    end
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      if (exp_ready && in_valid) push_vector(in);
    end
  end

  // Offer a vector and hold it until the accepting edge has passed.
  task automatic send(input logic [N-1:0] v);
    bit ok = 1'b0;
    @(posedge clk) #1;
    in       = v;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk) #1;
    in_valid = 1'b0;
    in       = N'($urandom);  // must not affect the latched vector
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // Reset: handshakes forced low while rst is high.
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out", out, 0);
    check("post_rst_out_last", out_last, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);

    // Single bit: index 2 appears the cycle after accept, as the last beat.
    send(4'b0100);
    @(negedge clk);
    check("single_valid", out_valid, 1'b1);
    check("single_out", out, 2);
    check("single_last", out_last, 1'b1);
    @(negedge clk);
    check("single_busy_after", busy, 1'b0);
    check("single_ready_after", in_ready, 1'b1);

    // Multi-hot with continuous ready: 0, 1, 3 (scoreboard checks order).
    send(4'b1011);
    wait_idle();

    // Backpressure: index 1 held for 3 stalled cycles, then 1, 2.
    out_ready = 1'b0;
    send(4'b0110);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_out", out, 1);
      check("bp_hold_last", out_last, 1'b0);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    wait_idle();

    // Zero vector: accepted, dropped, block stays idle.
    send(4'b0000);
    @(negedge clk);
    check("zero_busy", busy, 1'b0);
    check("zero_out_valid", out_valid, 1'b0);
    check("zero_in_ready", in_ready, 1'b1);

    // ena stall before the first output transfer: then beats 0, 3.
    send(4'b1001);
    ena = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("ena_stall_valid", out_valid, 1'b0);
      check("ena_stall_busy", busy, 1'b1);
    end
    @(posedge clk) #1;
    ena = 1'b1;
    wait_idle();

    // Reset mid-operation after beats 0 and 1 of 4'b1111.
    send(4'b1111);
    @(posedge clk);  // beat 0 consumed
    @(posedge clk);  // beat 1 consumed
    #1 rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    send(4'b1000);
    @(negedge clk);
    check("after_rst_out", out, 3);
    check("after_rst_last", out_last, 1'b1);
    wait_idle();

    // Randomized traffic with random enable, backpressure and rare resets.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk) #1;
      in        = N'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      ena       = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk) #1;
    rst       = 1'b0;
    ena       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_4_to_2_serial.md
Name: encoder_4_to_2_serial

Overview:
- Sequential counterpart of the 2-to-4 decoder.
- Accepts a 4-bit (generally N-bit) request vector through a valid/ready handshake and latches it.
- Emits the binary index of every set bit, one index per accepted output beat, lowest index first.
- Used wherever a one-hot or multi-hot vector must be turned back into a stream of binary select codes.

Parameters:
N, 4, width of the input vector; must be a power of two and at least 2
W, $clog2(N), width of the output index; derived from N, not overridden

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  module enable; when low, all handshakes are stalled and state is held
in  input  N  request vector
in_valid  input  1  in holds a vector to be accepted
in_ready  output  1  block can accept a vector this cycle
out  output  W  binary index of the lowest pending set bit
out_valid  output  1  out holds a valid index
out_ready  input  1  downstream consumes out this cycle
out_last  output  1  current out is the final pending bit of the latched vector
busy  output  1  a latched vector still has pending bits

Behaviour:
- Registered state:
  - state: IDLE or BUSY.
  - pending[N-1:0].
- Reset, evaluated on the clock edge while rst=1:
  - state=IDLE, pending=0.
  - From the following cycle, out=0, out_valid=0, out_last=0, busy=0 and in_ready=ena.
  - While rst is high, in_ready=0 and out_valid=0 combinationally.
  - No transfer is recorded in a cycle where rst=1.
- Output logic is combinational from registered state and ena:
  - in_ready = ena & (state==IDLE) & ~rst.
  - out_valid = ena & (state==BUSY) & ~rst.
  - out = index of the lowest set bit of pending. out=0 when pending=0.
  - out_last = out_valid & (pending has exactly one bit set).
  - busy = (state==BUSY). busy is not gated by ena.
- IDLE state:
  - An input transfer occurs when in_valid & in_ready.
  - If in != 0: pending<=in, state<=BUSY. The first index is presented on the next cycle, giving a latency of 1 cycle from accept to the first out_valid.
  - If in == 0: the vector is accepted and discarded, no output beat is produced, and state stays IDLE.
- BUSY state:
  - An output transfer occurs when out_valid & out_ready.
  - On an output transfer, the bit at index out is cleared in pending.
  - If that bit was the last one (out_last=1), state<=IDLE and pending<=0.
  - A vector with K set bits produces exactly K beats, strictly ascending in index.
- Back-to-back operation:
  - Input is not accepted in the same cycle as the last output beat (in_ready=0 while BUSY).
  - The next vector is accepted no earlier than the cycle after out_last is consumed.
  - Minimum period for a K-bit vector is K+1 cycles.
- Stall rules:
  - out_ready=0 holds out, out_valid and out_last stable, and pending is unchanged.
  - in_valid low in IDLE leaves the state unchanged.
- ena=0:
  - in_ready=0 and out_valid=0.
  - state and pending are held.
  - When ena returns high, output resumes at the same index with no beat lost or duplicated.
- Reset mid-operation: rst=1 in BUSY discards pending bits; no further beats are produced for that vector.
- Vector latch: the in value is sampled only on the transfer cycle. Later changes to in while BUSY have no effect.
- All-ones vector (N=4, in=4'b1111): emits 0,1,2,3. out_last is high on index 3 only.

Test Plan:
- Reset then single bit:
  - Stimulus: rst for 2 cycles, then in=4'b0100 with in_valid=1, ena=1, out_ready=1.
  - Response: the cycle after accept, out=2, out_valid=1, out_last=1. The next cycle, busy=0 and in_ready=1.
- Multi-hot with continuous ready:
  - Stimulus: in=4'b1011, out_ready=1.
  - Response: out beats are 0, 1, 3 on three consecutive cycles. out_last=1 only on 3. in_ready=0 throughout.
- Backpressure:
  - Stimulus: in=4'b0110, out_ready=0 for 3 cycles, then 1.
  - Response: out=1 is held stable with out_valid=1 for 3 cycles, then beats are 1, 2. No beat is dropped or duplicated.
- Zero vector and ena stall:
  - Zero vector: in=4'b0000 is accepted; no out_valid follows and the block stays IDLE.
  - ena stall: in=4'b1001 is accepted, then ena=0 for 2 cycles before the first output transfer. While ena is low, out_valid=0 and busy=1. When ena returns, beats are 0, 3.
- Reset mid-operation:
  - Stimulus: in=4'b1111; after the beats 0 and 1 complete, assert rst for 1 cycle.
  - Response: out_valid=0, busy=0, pending cleared. A following in=4'b1000 yields a single beat out=3 with out_last=1.
